key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter N_KEYS, default 6, meaning number of key inputs, arranged as up/down pairs: bit 2i = up, bit 2i+1 = down. Must be even.
REQ-002 Parameter DB_CNT, default 200, meaning debounce stability window in CP cycles (20 ms at 10 kHz).
REQ-003 Parameter RPT_DELAY, default 5000, meaning hold time in CP cycles before auto-repeat starts (0.5 s).
REQ-004 Parameter RPT_RATE, default 1000, meaning CP cycles between auto-repeat pulses (0.1 s).
REQ-005 Parameter ACTIVE_LOW, default 1, meaning a raw key reads 0 when pressed.
REQ-006 Port CP, input, 1 bit: the single clock (10 kHz scan clock); one clock; all state on rising edge.
REQ-007 Port nCR, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port key_raw, input, N_KEYS bits: asynchronous pushbutton pins, order {SD,SU,MD,MU,HD,HU} by default.
REQ-009 Port key_pulse, output, N_KEYS bits: one-CP-cycle step pulses feeding the time-adjust up/down inputs.
REQ-010 Port key_level, output, N_KEYS bits: debounced pressed level, 1 = pressed.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchronizer and be polarity-normalised to pressed = 1 before any other logic.
REQ-012 Each key SHALL have an independent FSM, with one shared-width counter per key sized for max(DB_CNT, RPT_DELAY, RPT_RATE).
REQ-013 FSM states SHALL be IDLE, PRESS_DB, HELD, REPEAT and RELEASE_DB.
REQ-014 IDLE: a synchronized press SHALL go to PRESS_DB with cnt=0.
REQ-015 PRESS_DB: a release SHALL return to IDLE with no pulse; otherwise cnt counts up.
REQ-016 PRESS_DB: when cnt = DB_CNT-1 and the key is still pressed, the FSM SHALL go to HELD, emit one pulse and clear cnt.
REQ-017 HELD: a release SHALL go to RELEASE_DB with cnt=0.
REQ-018 HELD: when cnt = RPT_DELAY-1, the FSM SHALL go to REPEAT, emit one pulse and clear cnt.
REQ-019 REPEAT: a pulse SHALL be emitted each time cnt = RPT_RATE-1, with cnt then cleared; a release SHALL go to RELEASE_DB.
REQ-020 RELEASE_DB: a press SHALL return to HELD with cnt=0 and no pulse, so bounce never re-triggers.
REQ-021 RELEASE_DB: when cnt = DB_CNT-1 and the key is still released, the FSM SHALL go to IDLE.
REQ-022 Latency: for a pin held pressed from edge t, the first key_pulse SHALL assert exactly at edge t+2+DB_CNT and SHALL be high for exactly 1 cycle.
REQ-023 key_level SHALL be 1 in HELD, REPEAT and RELEASE_DB, and 0 otherwise.
REQ-024 Pair conflict: while both keys of a pair have key_level=1, the pulses of both keys in that pair SHALL be suppressed; their FSMs continue unaffected.
REQ-025 Keys in different pairs SHALL be fully independent; simultaneous pulses on different pairs are permitted.
REQ-026 Counters SHALL saturate at their terminal count and never wrap.

Reset
REQ-027 nCR low SHALL asynchronously force every FSM to IDLE, every counter to 0, synchronizer flops to the released level, and key_pulse and key_level to 0.
REQ-028 Reset release during a held key SHALL require a full DB_CNT window before the first pulse; no pulse is emitted on the reset edge.
REQ-029 Reset asserted mid-REPEAT SHALL terminate pulses within the same cycle.

Configuration
REQ-030 Macro KEY_AUTOREPEAT_EN defined: REPEAT state and the RPT_DELAY/RPT_RATE behaviour are compiled in, as in REQ-018 and REQ-019.
REQ-031 Macro KEY_AUTOREPEAT_EN undefined: the REPEAT state and repeat logic SHALL be absent; HELD persists until release, giving exactly one pulse per debounced press; RPT_DELAY and RPT_RATE are ignored.

Verification (defaults, KEY_AUTOREPEAT_EN defined unless stated)
REQ-032 Clean press: HU pin low at cycle 10, held 300 cycles -> exactly one key_pulse[0] at cycle 212; key_level[0]=1 from 212; no other bits active.
REQ-033 Bounce: MU toggles every 30 cycles for 150 cycles, then stays low -> no pulse during bounce; a single pulse 202 cycles after the final low edge.
REQ-034 Auto-repeat: SU held for 7000 cycles -> pulses at press+202, +5202, +6202; no further pulses; key_level falls 200 cycles after release plus synchronizer delay.
REQ-035 Pair conflict: HU pressed, HD pressed 50 cycles later, both held 6000 cycles -> HU's first pulse is emitted (HD not yet debounced); no pulses from either key while both levels are 1.
REQ-036 Reset mid-operation: nCR low during REPEAT of SD -> key_pulse and key_level are 0 immediately; after nCR high with SD still held, the first pulse appears at DB_CNT+2 cycles.
REQ-037 KEY_AUTOREPEAT_EN undefined: MD held for 7000 cycles -> exactly one pulse at press+202.

Source files
------------

// File: rtl/key_conditioner.sv
// Debounce / auto-repeat conditioner for up/down pushbutton pairs on the CP scan clock.
// Define KEY_AUTOREPEAT_EN to compile in the hold-to-repeat behaviour.

module key_fsm #(
  parameter int DB_CNT     = 200,
`ifdef KEY_AUTOREPEAT_EN
  parameter int RPT_DELAY  = 5000,
  parameter int RPT_RATE   = 1000,
`endif
  parameter int ACTIVE_LOW = 1,
  parameter int CW         = 13
) (
  input  logic CP,
  input  logic nCR,
  input  logic key_raw_i,
  output logic pulse_o,
  output logic level_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
`ifdef KEY_AUTOREPEAT_EN
    REPEAT     = 3'd3,
`endif
    RELEASE_DB = 3'd4
  } state_t;

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] RTE_LAST = CW'(RPT_RATE - 1);
`endif

  logic [1:0]    sync_q;
  logic          pressed;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;
  logic          level_q;

  // Normalise to pressed=1 first so reset value 0 is the released level.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) sync_q <= '0;
    else      sync_q <= {sync_q[0], (ACTIVE_LOW != 0) ? ~key_raw_i : key_raw_i};
  end

  assign pressed = sync_q[1];

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pressed) state_q <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q <= RELEASE_DB;
            cnt_q   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (cnt_q == DLY_LAST) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          end
`else
          else begin
            cnt_q <= '0;
          end
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        REPEAT: begin
          if (!pressed) begin
            state_q <= RELEASE_DB;
            cnt_q   <= '0;
          end else if (cnt_q == RTE_LAST) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          end
        end
`endif
        RELEASE_DB: begin
          // A bounce back to pressed resumes HELD silently.
          if (pressed) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;

endmodule

module key_conditioner #(
  parameter int N_KEYS     = 6,
  parameter int DB_CNT     = 200,
  parameter int RPT_DELAY  = 5000,
  parameter int RPT_RATE   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              CP,
  input  logic              nCR,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_level
);

  localparam int CNT_MAX = (DB_CNT > RPT_DELAY) ?
                           ((DB_CNT > RPT_RATE) ? DB_CNT : RPT_RATE) :
                           ((RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE);
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int N_PAIRS = N_KEYS / 2;

  logic [N_KEYS-1:0] pulse_raw;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_fsm #(
      .DB_CNT     (DB_CNT),
`ifdef KEY_AUTOREPEAT_EN
      .RPT_DELAY  (RPT_DELAY),
      .RPT_RATE   (RPT_RATE),
`endif
      .ACTIVE_LOW (ACTIVE_LOW),
      .CW         (CW)
    ) u_key (
      .CP        (CP),
      .nCR       (nCR),
      .key_raw_i (key_raw[k]),
      .pulse_o   (pulse_raw[k]),
      .level_o   (key_level[k])
    );
  end

  // Up and down held together is ambiguous: mute the pair, FSMs keep running.
  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    logic conflict;
    assign conflict             = key_level[2*p] & key_level[2*p+1];
    assign key_pulse[2*p+1:2*p] = pulse_raw[2*p+1:2*p] & {2{~conflict}};
  end

  if ((N_KEYS % 2) != 0) begin : g_odd
    assign key_pulse[N_KEYS-1] = pulse_raw[N_KEYS-1];
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at default parameters; repeat expectations
// follow KEY_AUTOREPEAT_EN.

module tb_key_conditioner;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic [5:0] key_raw = 6'b111111;
  logic [5:0] key_pulse;
  logic [5:0] key_level;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {int k; int t;} ev_t;
  ev_t evq[$];

  key_conditioner #(
    .N_KEYS(6), .DB_CNT(200), .RPT_DELAY(5000), .RPT_RATE(1000), .ACTIVE_LOW(1)
  ) dut (
    .CP        (CP),
    .nCR       (nCR),
    .key_raw   (key_raw),
    .key_pulse (key_pulse),
    .key_level (key_level)
  );

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  // Pulse log: (key, edge number) for every high key_pulse bit.
  always @(negedge CP)
    for (int k = 0; k < 6; k++)
      if (key_pulse[k] === 1'b1) evq.push_back('{k, cyc});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CP);
  endtask

  function automatic ev_t ev_at(input int i);
    ev_t e;
    e.k = -1;
    e.t = -1;
    if (i < evq.size()) e = evq[i];
    return e;
  endfunction

  initial begin
    int t0, f, s, h, r;

    // Reset state
    repeat (3) @(negedge CP);
    check("rst_pulse", 32'(key_pulse), 32'h0);
    check("rst_level", 32'(key_level), 32'h0);
    nCR = 1'b1;
    wait_cyc(cyc + 5);

    // Clean HU press
    t0 = cyc + 10;
    wait_cyc(t0 - 1);
    evq.delete();
    key_raw[0] = 1'b0;
    wait_cyc(t0 + 201);
    check("hu_pre_pulse", 32'(key_pulse), 32'h0);
    check("hu_pre_level", 32'(key_level), 32'h0);
    wait_cyc(t0 + 202);
    check("hu_pulse", 32'(key_pulse), 32'h01);
    check("hu_level", 32'(key_level), 32'h01);
    wait_cyc(t0 + 203);
    check("hu_pulse_1cyc", 32'(key_pulse), 32'h0);
    wait_cyc(t0 + 299);
    key_raw[0] = 1'b1;
    wait_cyc(t0 + 501);
    check("hu_level_hold", 32'(key_level), 32'h01);
    wait_cyc(t0 + 502);
    check("hu_level_fall", 32'(key_level), 32'h0);
    wait_cyc(t0 + 510);
    check("hu_n_pulses", 32'(evq.size()), 32'd1);
    check("hu_ev_key", 32'(ev_at(0).k), 32'd0);
    check("hu_ev_time", 32'(ev_at(0).t), 32'(t0 + 202));

    // MU bounce: low/high every 30 cycles, final low edge at +120
    s = cyc + 5;
    evq.delete();
    for (int i = 0; i < 5; i++) begin
      wait_cyc(s + 30 * i - 1);
      key_raw[2] = (i % 2 == 1);
    end
    f = s + 120;
    wait_cyc(f + 201);
    check("mu_no_early", 32'(evq.size()), 32'd0);
    wait_cyc(f + 202);
    check("mu_pulse", 32'(key_pulse), 32'h04);
    wait_cyc(f + 299);
    key_raw[2] = 1'b1;
    wait_cyc(f + 520);
    check("mu_n_pulses", 32'(evq.size()), 32'd1);
    check("mu_ev_time", 32'(ev_at(0).t), 32'(f + 202));
    check("mu_level_end", 32'(key_level), 32'h0);

    // SU held 7000 cycles
    s = cyc + 5;
    wait_cyc(s - 1);
    evq.delete();
    key_raw[4] = 1'b0;
    wait_cyc(s + 5202);
`ifdef KEY_AUTOREPEAT_EN
    check("su_rpt1", 32'(key_pulse), 32'h10);
`else
    check("su_rpt1", 32'(key_pulse), 32'h0);
`endif
    wait_cyc(s + 6999);
    key_raw[4] = 1'b1;
    wait_cyc(s + 7201);
    check("su_level_hold", 32'(key_level), 32'h10);
    wait_cyc(s + 7202);
    check("su_level_fall", 32'(key_level), 32'h0);
    wait_cyc(s + 7210);
    check("su_ev0", 32'(ev_at(0).t), 32'(s + 202));
`ifdef KEY_AUTOREPEAT_EN
    check("su_n_pulses", 32'(evq.size()), 32'd3);
    check("su_ev1", 32'(ev_at(1).t), 32'(s + 5202));
    check("su_ev2", 32'(ev_at(2).t), 32'(s + 6202));
    check("su_ev2_key", 32'(ev_at(2).k), 32'd4);
`else
    check("su_n_pulses", 32'(evq.size()), 32'd1);
    check("su_ev1", 32'(ev_at(1).t), 32'hFFFF_FFFF);
`endif

    // HU then HD 50 cycles later, both held
    h = cyc + 5;
    wait_cyc(h - 1);
    evq.delete();
    key_raw[0] = 1'b0;
    wait_cyc(h + 49);
    key_raw[1] = 1'b0;
    wait_cyc(h + 252);
    check("pair_levels", 32'(key_level), 32'h03);
    check("pair_hd_muted", 32'(key_pulse), 32'h0);
    wait_cyc(h + 5999);
    key_raw[1:0] = 2'b11;
    wait_cyc(h + 6201);
    check("pair_level_hold", 32'(key_level), 32'h03);
    wait_cyc(h + 6210);
    check("pair_level_fall", 32'(key_level), 32'h0);
    check("pair_n_pulses", 32'(evq.size()), 32'd1);
    check("pair_ev_key", 32'(ev_at(0).k), 32'd0);
    check("pair_ev_time", 32'(ev_at(0).t), 32'(h + 202));

    // SD held, reset asserted while a pulse is high
    s = cyc + 5;
    wait_cyc(s - 1);
    key_raw[5] = 1'b0;
    wait_cyc(s + 6202);
`ifdef KEY_AUTOREPEAT_EN
    check("sd_rpt_pulse", 32'(key_pulse), 32'h20);
`else
    check("sd_rpt_pulse", 32'(key_pulse), 32'h0);
`endif
    nCR = 1'b0;
    #1;
    check("sd_rst_pulse", 32'(key_pulse), 32'h0);
    check("sd_rst_level", 32'(key_level), 32'h0);
    wait_cyc(s + 6205);
    nCR = 1'b1;
    evq.delete();
    r = s + 6206;
    wait_cyc(r + 201);
    check("sd_no_early", 32'(evq.size()), 32'd0);
    wait_cyc(r + 202);
    check("sd_first_pulse", 32'(key_pulse), 32'h20);
    wait_cyc(r + 299);
    key_raw[5] = 1'b1;
    wait_cyc(r + 520);
    check("sd_n_pulses", 32'(evq.size()), 32'd1);
    check("sd_level_end", 32'(key_level), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
